// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift mode encoding.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_t;

endpackage

// File: rtl/shift_level.sv
// One combinational barrel-shifter level: shifts by DIST when en_i is set.
module shift_level
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  shift_mode_t      mode_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      unique case (mode_i)
        SH_SLL:  data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SH_SRL:  data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
        // fill_i is the operand sign captured at the input, not this level's MSB
        SH_SRA:  data_o = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
        SH_ROR:  data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready handshake, flush and
// tag pass-through. Stage registers follow the levels selected by PIPE_MASK.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned              WIDTH     = 32,
  parameter int unsigned              TAG_W     = 5,
  parameter logic [$clog2(WIDTH)-1:0] PIPE_MASK = 5'b00100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two and at least 4");
  end

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    shift_mode_t        mode;
    logic               fill;
    logic [TAG_W-1:0]   tag;
  } beat_t;

  beat_t in_beat;
  beat_t last_beat;
  logic  stg_vld [SHAMT_W];
  logic  adv     [SHAMT_W];
  logic  adv_last;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_data_d, out_data_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;

  assign in_beat = '{
    valid: in_valid,
    data:  in_data,
    shamt: in_shamt,
    mode:  shift_mode_t'(in_mode),
    fill:  in_data[WIDTH-1],
    tag:   in_tag
  };

  // Ready chain: walk back from the output register; each present stage passes
  // ready upstream when it is empty or its successor advances.
  assign adv_last = !out_valid_q || out_ready;

  always_comb begin
    logic rdy;
    rdy = adv_last;
    for (int i = SHAMT_W - 1; i >= 0; i--) begin
      if (PIPE_MASK[i]) begin
        rdy = !stg_vld[i] || rdy;
      end
      adv[i] = rdy;
    end
  end

  assign in_ready = adv[0];

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_lvl
    beat_t            lvl_in;
    beat_t            lvl_out;
    beat_t            lvl_next;
    logic [WIDTH-1:0] sh_data;

    if (i == 0) begin : g_first
      assign lvl_in = in_beat;
    end else begin : g_chain
      assign lvl_in = g_lvl[i-1].lvl_next;
    end

    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (2 ** i)
    ) u_level (
      .data_i (lvl_in.data),
      .en_i   (lvl_in.shamt[i]),
      .mode_i (lvl_in.mode),
      .fill_i (lvl_in.fill),
      .data_o (sh_data)
    );

    always_comb begin
      lvl_out      = lvl_in;
      lvl_out.data = sh_data;
    end

    if (PIPE_MASK[i]) begin : g_reg
      beat_t stg_d, stg_q;

      always_comb begin
        stg_d = stg_q;
        if (flush) begin
          stg_d.valid = 1'b0;
        end else if (adv[i]) begin
          stg_d.valid = lvl_out.valid;
          if (lvl_out.valid) begin
            stg_d = lvl_out;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg_q <= '0;
        end else begin
          stg_q <= stg_d;
        end
      end

      assign lvl_next   = stg_q;
      assign stg_vld[i] = stg_q.valid;
    end else begin : g_comb
      assign lvl_next   = lvl_out;
      assign stg_vld[i] = 1'b0;
    end
  end

  assign last_beat = g_lvl[SHAMT_W-1].lvl_next;

  // Shift control fields are fully consumed by the last level.
  logic unused_last;
  assign unused_last = ^{last_beat.shamt, last_beat.mode, last_beat.fill};

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (adv_last) begin
      out_valid_d = last_beat.valid;
      if (last_beat.valid) begin
        out_data_d = last_beat.data;
        out_tag_d  = last_beat.tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter with a queue-based result model.
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TAG_W   = 5;
  localparam int unsigned SHAMT_W = 5;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  int nvec;
  int nfail;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t        model_q[$];
  exp_t        mon_e;
  logic        stall_seen;
  logic [31:0] stall_data;
  logic [4:0]  stall_tag;

  pipelined_barrel_shifter #(
    .WIDTH     (WIDTH),
    .TAG_W     (TAG_W),
    .PIPE_MASK (5'b00100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endfunction

  function automatic logic [31:0] model(logic [31:0] d, int s, logic [1:0] m);
    logic [63:0] dd;
    case (m)
      SH_SLL:  return d << s;
      SH_SRL:  return d >> s;
      SH_SRA:  return 32'($signed(d) >>> s);
      default: begin
        dd = {d, d} >> s;
        return dd[31:0];
      end
    endcase
  endfunction

  // Compare process: inputs are stable at the falling edge, so the handshakes that
  // the next rising edge will perform are decided here.
  initial begin
    stall_seen = 1'b0;
    stall_data = '0;
    stall_tag  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_seen) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", 64'(out_data), 64'(stall_data));
          check("stall_tag", 64'(out_tag), 64'(stall_tag));
        end
        if (out_valid && out_ready) begin
          if (model_q.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL spurious_out: got data %0h tag %0d, required no beat", out_data,
                     out_tag);
          end else begin
            mon_e = model_q.pop_front();
            check("out_data", 64'(out_data), 64'(mon_e.data));
            check("out_tag", 64'(out_tag), 64'(mon_e.tag));
          end
        end
        stall_seen = out_valid && !out_ready && !flush;
        stall_data = out_data;
        stall_tag  = out_tag;
        if (flush) begin
          model_q.delete();
        end else if (in_valid && in_ready) begin
          model_q.push_back('{data: model(in_data, int'(in_shamt), in_mode), tag: in_tag});
        end
      end else begin
        model_q.delete();
        stall_seen = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish before 200000");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty pipeline; checks exact two-cycle latency and a literal result.
  task automatic single(string name, logic [1:0] m, logic [31:0] d, logic [4:0] s,
                        logic [4:0] t, logic [31:0] exp);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_shamt = s;
    in_tag   = t;
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, 64'(out_valid), 64'd0);
    cyc();
    @(negedge clk);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_data"}, 64'(out_data), 64'(exp));
    check({name, "_tag"}, 64'(out_tag), 64'(t));
    cyc();
  endtask

  initial begin
    int run;
    int best;
    int total;
    int k;
    int acc_stall;
    logic acc;

    nvec      = 0;
    nfail     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // 1. reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    cyc();

    // 2. modes at shamt 4
    single("sll4", SH_SLL, 32'h8000_00F1, 5'd4, 5'd1, 32'h0000_0F10);
    single("srl4", SH_SRL, 32'h8000_00F1, 5'd4, 5'd2, 32'h0800_000F);
    single("sra4", SH_SRA, 32'h8000_00F1, 5'd4, 5'd3, 32'hF800_000F);
    single("ror4", SH_ROR, 32'h8000_00F1, 5'd4, 5'd4, 32'h1800_000F);
    single("zero_shamt", SH_SRA, 32'h9ABC_DEF0, 5'd0, 5'd5, 32'h9ABC_DEF0);

    // 3. back-to-back beats, shamt and tag 0..7
    run   = 0;
    best  = 0;
    total = 0;
    for (int j = 0; j < 14; j++) begin
      if (j < 8) begin
        in_valid = 1'b1;
        in_data  = 32'hA5C3_0F81;
        in_shamt = 5'(j);
        in_tag   = 5'(j);
        in_mode  = 2'(j % 4);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid) begin
        run++;
        total++;
      end else begin
        run = 0;
      end
      if (run > best) best = run;
      if (j == 7) begin
        check("b2b_srl5_data", 64'(out_data), 64'h052E_187C);
        check("b2b_srl5_tag", 64'(out_tag), 64'd5);
      end
      if (j == 9) begin
        check("b2b_ror7_data", 64'(out_data), 64'h034B_861F);
        check("b2b_ror7_tag", 64'(out_tag), 64'd7);
      end
      cyc();
    end
    check("b2b_total", 64'(total), 64'd8);
    check("b2b_consecutive", 64'(best), 64'd8);
    single("sra31", SH_SRA, 32'h8000_0000, 5'd31, 5'd9, 32'hFFFF_FFFF);

    // 4. backpressure: out_ready low for 5 cycles starting from an empty pipeline
    k         = 0;
    acc_stall = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      out_ready = !(c < 5);
      in_valid  = 1'b1;
      in_data   = 32'h1234_5678 ^ 32'(k * 32'h0101_0101);
      in_shamt  = 5'(k * 3);
      in_mode   = 2'(k);
      in_tag    = 5'(k + 8);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c < 5 && acc) acc_stall++;
      if (c == 4) check("bp_in_ready_low", 64'(in_ready), 64'd0);
      cyc();
      if (acc) k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_accepts_in_stall", 64'(acc_stall), 64'd2);
    check("bp_all_accepted", 64'(k), 64'd8);
    repeat (4) cyc();

    // 5. flush with two beats in flight and a third presented
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF + 32'(j);
      in_shamt = 5'(j + 1);
      in_mode  = SH_SLL;
      in_tag   = 5'(20 + j);
      cyc();
    end
    in_data = 32'hCAFE_F00D;
    in_tag  = 5'd22;
    flush   = 1'b1;
    @(negedge clk);
    check("flush_pre_valid", 64'(out_valid), 64'd1);
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    cyc();
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("flush_empty", 64'(out_valid), 64'd0);
      cyc();
    end
    single("post_flush", SH_ROR, 32'h0000_0001, 5'd1, 5'd23, 32'h8000_0000);

    // 6. asynchronous reset pulse between clock edges
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = 32'h0F0F_0F0F;
      in_shamt = 5'(j);
      in_mode  = SH_SRL;
      in_tag   = 5'(24 + j);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("arst_pre_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    model_q.delete();
    stall_seen = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("arst_empty", 64'(out_valid), 64'd0);
    end
    cyc();
    single("post_arst", SH_SLL, 32'h0000_0001, 5'd31, 5'd30, 32'h8000_0000);

    repeat (4) cyc();
    check("model_drained", 64'(model_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
